// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/MEM requesters, the arbiter and the unified memory.
// The slave modport is the arbiter's view; the master modport is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    logic              err;
    logic              halt_req;
    logic              halted;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_stall,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_ack, d_rdata, d_stall,
        output err,
        input  halt_req,
        output halted,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_stall,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_ack, d_rdata, d_stall,
        input  err,
        output halt_req,
        input  halted,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port variable-latency memory between instruction fetch and the
// MEM stage, with fetch anti-starvation, an ack timeout and a sticky halt.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = 4;
    localparam int WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t              state_r;
    logic [STREAK_W-1:0] d_streak_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                halt_pending_r;
    logic                halted_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [BE_W-1:0]     mem_be_r;

    logic                busy_s;
    logic                halt_now_s;
    logic                timeout_s;
    logic                done_s;
    logic                grant_d_s;
    logic                grant_if_s;
    logic                if_ack_s;
    logic                d_ack_s;
    logic [DATA_W-1:0]   rdata_s;

    // Arbitration decision, completion detection and the ack/data return path.
    always_comb begin
        busy_s     = (state_r == BUSY_IF) || (state_r == BUSY_D);
        // halt_req seen this cycle already blocks a grant, not just the registered flag
        halt_now_s = halt_pending_r || bus.halt_req;

        if (TIMEOUT != 32'sd0) begin
            timeout_s = busy_s && !bus.mem_ack && (wait_cnt_r == WAIT_W'(TIMEOUT - 1));
        end else begin
            timeout_s = 1'b0;
        end

        done_s   = busy_s && (bus.mem_ack || timeout_s);
        if_ack_s = done_s && (state_r == BUSY_IF);
        d_ack_s  = done_s && (state_r == BUSY_D);

        if (timeout_s) begin
            rdata_s = {DATA_W{1'b0}};
        end else begin
            rdata_s = bus.mem_rdata;
        end

        if ((state_r == IDLE) && !halt_now_s) begin
            grant_d_s  = bus.d_req &&
                         !(bus.if_req && (d_streak_r == STREAK_W'(MAX_D_STREAK)));
            grant_if_s = !grant_d_s && bus.if_req;
        end else begin
            grant_d_s  = 1'b0;
            grant_if_s = 1'b0;
        end
    end

    assign bus.if_ack    = if_ack_s;
    assign bus.d_ack     = d_ack_s;
    assign bus.if_rdata  = rdata_s;
    assign bus.d_rdata   = rdata_s;
    assign bus.err       = timeout_s;
    assign bus.if_stall  = bus.if_req && !if_ack_s;
    assign bus.d_stall   = bus.d_req && !d_ack_s;
    assign bus.halted    = halted_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_be    = mem_be_r;

    // Arbiter FSM with registered memory-side outputs, streak/wait counters and halt flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            d_streak_r     <= {STREAK_W{1'b0}};
            wait_cnt_r     <= {WAIT_W{1'b0}};
            halt_pending_r <= 1'b0;
            halted_r       <= 1'b0;
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_wdata_r    <= {DATA_W{1'b0}};
            mem_be_r       <= {BE_W{1'b0}};
        end else begin
            halt_pending_r <= halt_pending_r | bus.halt_req;

            case (state_r)
                IDLE: begin
                    if (halt_now_s) begin
                        state_r   <= HALTED;
                        halted_r  <= 1'b1;
                        mem_req_r <= 1'b0;
                    end else if (grant_d_s) begin
                        state_r     <= BUSY_D;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= bus.d_we;
                        mem_addr_r  <= bus.d_addr;
                        mem_wdata_r <= bus.d_wdata;
                        mem_be_r    <= bus.d_be;
                        wait_cnt_r  <= {WAIT_W{1'b0}};
                        // streak only accumulates while fetch is actually being held off
                        if (!bus.if_req) begin
                            d_streak_r <= {STREAK_W{1'b0}};
                        end else if (d_streak_r < STREAK_W'(MAX_D_STREAK)) begin
                            d_streak_r <= d_streak_r + STREAK_W'(1);
                        end else begin
                            d_streak_r <= d_streak_r;
                        end
                    end else if (grant_if_s) begin
                        state_r     <= BUSY_IF;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= bus.if_addr;
                        mem_wdata_r <= {DATA_W{1'b0}};
                        mem_be_r    <= {BE_W{1'b1}};
                        wait_cnt_r  <= {WAIT_W{1'b0}};
                        d_streak_r  <= {STREAK_W{1'b0}};
                    end else begin
                        mem_req_r <= 1'b0;
                    end
                end

                BUSY_IF, BUSY_D: begin
                    if (done_s) begin
                        mem_req_r  <= 1'b0;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                        if (halt_now_s) begin
                            state_r  <= HALTED;
                            halted_r <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (wait_cnt_r != {WAIT_W{1'b1}}) begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end

                HALTED: begin
                    mem_req_r <= 1'b0;
                    halted_r  <= 1'b1;
                end

                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
